// File: rtl/ece385_cmp_pkg.sv
// Shared types for the sequential nibble comparator: FSM state encoding,
// cascade triple layout and its reset value.
package ece385_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } casc_t;

  // "Equal so far" is the neutral starting point for an LSB-first cascade.
  localparam casc_t CASC_RESET = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ece385_cmp_seq_cmp4.sv
// 4-bit cascadable magnitude comparator. The cascade inputs carry the verdict
// of the less significant nibbles; this nibble overrides it unless equal.
module ece385_cmp_seq_cmp4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_lt,
  input  logic       i_eq,
  input  logic       i_gt,
  output logic       o_lt,
  output logic       o_eq,
  output logic       o_gt
);

  always_comb begin
    o_lt = i_lt;
    o_eq = i_eq;
    o_gt = i_gt;
    if (i_a > i_b) begin
      o_lt = 1'b0;
      o_eq = 1'b0;
      o_gt = 1'b1;
    end else if (i_a < i_b) begin
      o_lt = 1'b1;
      o_eq = 1'b0;
      o_gt = 1'b0;
    end
  end

endmodule

// File: rtl/ece385_cmp_seq.sv
// Sequential magnitude comparator: one shared 4-bit cascadable comparator is
// stepped LSB nibble first over NIBBLES cycles. ECE385_CMP_SEQ_SIGNED_EN
// selects a two's-complement compare (default build: unsigned).
//
// Handshake: start is sampled only in IDLE (busy=0); the edge that sees it
// latches A_in/B_in. res_valid is high exactly while in DONE and the result
// holds until an edge with res_ready=1, which returns to IDLE. A start on
// that same edge is not accepted because the FSM is still in DONE.
module ece385_cmp_seq
  import ece385_cmp_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A_in,
  input  logic [4*NIBBLES-1:0]   B_in,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   A_gt_B,
  output logic                   A_eq_B,
  output logic                   A_lt_B,
  output logic [1:0]             o_dbg_state
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  casc_t            r_casc;
  casc_t            r_res;
  casc_t            w_cmp;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic             w_last;
  logic             w_accept;
  logic             w_step;

  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_a_nib = 4'h0;
    w_b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
`ifdef ECE385_CMP_SEQ_SIGNED_EN
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    if (w_last) begin
      w_a_nib[3] = ~w_a_nib[3];
      w_b_nib[3] = ~w_b_nib[3];
    end
`endif
  end

  ece385_cmp_seq_cmp4 u_cmp4 (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_lt (r_casc.lt),
    .i_eq (r_casc.eq),
    .i_gt (r_casc.gt),
    .o_lt (w_cmp.lt),
    .o_eq (w_cmp.eq),
    .o_gt (w_cmp.gt)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= '0;
      r_casc <= CASC_RESET;
      r_res  <= CASC_RESET;
    end else if (w_accept) begin
      r_a    <= A_in;
      r_b    <= B_in;
      r_idx  <= '0;
      r_casc <= CASC_RESET;
    end else if (w_step) begin
      r_casc <= w_cmp;
      if (w_last) begin
        r_idx <= '0;
        r_res <= w_cmp;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign res_valid   = (r_state == ST_DONE);
  assign A_gt_B      = r_res.gt;
  assign A_eq_B      = r_res.eq;
  assign A_lt_B      = r_res.lt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ece385_cmp_seq.sv
// Bench for ece385_cmp_seq: a 4-nibble and a 1-nibble instance share clock
// and reset; table vectors, hand sequences for hold/reset, random pairs.
module tb_ece385_cmp_seq;

`ifdef ECE385_CMP_SEQ_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start4, ready4, busy4, valid4, gt4, eq4, lt4;
  logic [15:0] a4, b4;
  logic [1:0]  st4;
  logic        start1, ready1, busy1, valid1, gt1, eq1, lt1;
  logic [3:0]  a1, b1;
  logic [1:0]  st1;

  ece385_cmp_seq #(.NIBBLES(4)) dut4 (
    .Clk(clk), .Reset_n(rst_n), .start(start4), .A_in(a4), .B_in(b4),
    .busy(busy4), .res_valid(valid4), .res_ready(ready4),
    .A_gt_B(gt4), .A_eq_B(eq4), .A_lt_B(lt4), .o_dbg_state(st4)
  );

  ece385_cmp_seq #(.NIBBLES(1)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .start(start1), .A_in(a1), .B_in(b1),
    .busy(busy1), .res_valid(valid1), .res_ready(ready1),
    .A_gt_B(gt1), .A_eq_B(eq1), .A_lt_B(lt1), .o_dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: differing sign bits decide a signed compare outright.
  function automatic logic [2:0] model(input bit sel, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ma, mb;
    logic sa, sb;
    ma = sel ? {12'h0, a[3:0]} : a;
    mb = sel ? {12'h0, b[3:0]} : b;
    sa = sel ? a[3] : a[15];
    sb = sel ? b[3] : b[15];
    if (SG && (sa != sb)) return sa ? LT : GT;
    if (ma > mb) return GT;
    if (ma < mb) return LT;
    return EQ;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy4;
  endfunction
  function automatic logic get_valid(input bit sel);
    return sel ? valid1 : valid4;
  endfunction
  function automatic logic [2:0] get_res(input bit sel);
    return sel ? {gt1, eq1, lt1} : {gt4, eq4, lt4};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit sel, input logic [15:0] a, input logic [15:0] b,
                       input logic st, input logic rdy);
    if (sel) begin
      a1 = a[3:0]; b1 = b[3:0]; start1 = st; ready1 = rdy;
    end else begin
      a4 = a; b4 = b; start4 = st; ready4 = rdy;
    end
  endtask

  // Called at a negedge with the DUT idle; res_ready is held high throughout.
  task automatic run_cmp(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] exp, input string name);
    int cyc;
    logic [2:0] got;
    drive(sel, a, b, 1'b1, 1'b1);
    exp_q.push_back(exp);
    @(negedge clk);
    drive(sel, ~a, ~b, 1'b0, 1'b1);
    check({name, " busy_after_accept"}, 32'(get_busy(sel)), 32'd1);
    cyc = 0;
    while (!get_valid(sel) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), sel ? 32'd1 : 32'd4);
    got = get_res(sel);
    check({name, " result"}, 32'(got), 32'(exp_q.pop_front()));
    check({name, " onehot"}, 32'($onehot(got)), 32'd1);
    @(negedge clk);
    check({name, " idle_next"}, {30'd0, get_busy(sel), get_valid(sel)}, 32'd0);
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0] held;
    int cyc;

    vecs.push_back('{0, 16'h1234, 16'h1234, EQ});
    vecs.push_back('{0, 16'h8001, 16'h7FFF, SG ? LT : GT});
    vecs.push_back('{0, 16'h0F00, 16'h0E0F, GT});
    vecs.push_back('{0, 16'h0001, 16'h0002, LT});
    vecs.push_back('{0, 16'hFFFF, 16'h0000, SG ? LT : GT});
    vecs.push_back('{0, 16'h0000, 16'hFFFF, SG ? GT : LT});
    vecs.push_back('{0, 16'h8000, 16'h8000, EQ});
    vecs.push_back('{0, 16'h1000, 16'h0FFF, GT});
    vecs.push_back('{0, 16'h7FFF, 16'h8000, SG ? GT : LT});
    vecs.push_back('{1, 16'h0008, 16'h0007, SG ? LT : GT});
    vecs.push_back('{1, 16'h0003, 16'h0003, EQ});
    vecs.push_back('{1, 16'h0002, 16'h0009, SG ? GT : LT});
    vecs.push_back('{1, 16'h000F, 16'h000E, GT});

    rst_n = 1'b0;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("reset4 busy_valid", {30'd0, busy4, valid4}, 32'd0);
    check("reset4 result", 32'({gt4, eq4, lt4}), 32'(EQ));
    check("reset1 busy_valid", {30'd0, busy1, valid1}, 32'd0);
    check("reset1 result", 32'({gt1, eq1, lt1}), 32'(EQ));
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_cmp(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Hold in DONE with res_ready low while inputs churn and start pulses.
    drive(0, 16'h00F0, 16'h00F1, 1'b1, 1'b0);
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (!valid4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("hold latency", 32'(cyc), 32'd4);
    held = {gt4, eq4, lt4};
    check("hold result", 32'(held), 32'(LT));
    for (int i = 0; i < 10; i++) begin
      a4 = 16'($urandom);
      b4 = 16'($urandom);
      start4 = i[0];
      @(negedge clk);
      check($sformatf("hold cyc%0d", i), {28'd0, busy4, valid4, 2'd0} | 32'({gt4, eq4, lt4}) << 4,
            {28'd0, 2'b11, 2'd0} | 32'(LT) << 4);
    end
    start4 = 1'b1;
    ready4 = 1'b1;
    @(negedge clk);
    check("release idle", {30'd0, busy4, valid4}, 32'd0);
    start4 = 1'b0;
    @(negedge clk);
    check("coincident start ignored", 32'(busy4), 32'd0);
    check("result kept in idle", 32'({gt4, eq4, lt4}), 32'(LT));

    // Abort at nibble index 2.
    drive(0, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy_valid", {30'd0, busy4, valid4}, 32'd0);
    check("abort result", 32'({gt4, eq4, lt4}), 32'(EQ));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("no_pulse%0d", i), {30'd0, busy4, valid4}, 32'd0);
    end
    run_cmp(0, 16'h0000, 16'h0000, EQ, "post_reset");

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom_range(0, 65535));
      rb = (i % 8 == 0) ? ra : 16'($urandom_range(0, 65535));
      run_cmp(0, ra, rb, model(0, ra, rb), "rand4");
    end
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom_range(0, 15));
      rb = 16'($urandom_range(0, 15));
      run_cmp(1, ra, rb, model(1, ra, rb), "rand1");
    end

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ece385_cmp_seq.md
ECE385_CMP_SEQ -- requirements
Module: ece385_cmp_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, meaning operand width in 4-bit nibbles (legal range 1..16); WIDTH = 4*NIBBLES.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port Clk  input  1  system clock, all state on rising edge.
REQ-004 Port Reset_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request to compare A_in/B_in; sampled only in IDLE.
REQ-006 Port A_in  input  WIDTH  operand A, sampled on accepted start.
REQ-007 Port B_in  input  WIDTH  operand B, sampled on accepted start.
REQ-008 Port busy  output  1  high whenever state is not IDLE.
REQ-009 Port res_valid  output  1  result valid, high only in DONE.
REQ-010 Port res_ready  input  1  consumer accepts result.
REQ-011 Port A_gt_B, A_eq_B, A_lt_B  output  1 each  registered comparison result, one-hot when res_valid.

Function
REQ-012 The block SHALL time-share one 4-bit cascadable magnitude comparator, LSB nibble first, feeding each nibble's registered outputs into the next nibble's cascade inputs.
REQ-013 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after nibble NIBBLES-1; DONE->IDLE on res_ready.
REQ-014 On an accepted start the block SHALL latch A_in/B_in, clear nibble index to 0, and load cascade registers to lt=0, eq=1, gt=0.
REQ-015 Each RUN cycle SHALL compare nibble[index] of latched A/B with current cascade registers, register the three outputs into the cascade registers, and increment index.
REQ-016 On the RUN cycle with index==NIBBLES-1 the block SHALL load the comparator outputs into A_gt_B/A_eq_B/A_lt_B and enter DONE.
REQ-017 res_valid SHALL rise exactly NIBBLES cycles after the edge that accepts start (NIBBLES=4: 4 cycles).
REQ-018 Result outputs and res_valid SHALL hold stable in DONE until an edge with res_ready=1; that edge returns to IDLE and deasserts res_valid.
REQ-019 start SHALL be ignored while busy; a start coincident with the DONE->IDLE edge SHALL NOT be accepted (minimum issue interval NIBBLES+2 cycles).
REQ-020 Result outputs SHALL retain the last value in IDLE and RUN; A_in/B_in changes after acceptance SHALL NOT affect the result.
REQ-021 NIBBLES=1 SHALL complete in one RUN cycle.

Reset
REQ-022 Reset_n low SHALL immediately force IDLE, busy=0, res_valid=0, index=0, A_gt_B=0, A_eq_B=1, A_lt_B=0, cascade regs lt=0/eq=1/gt=0, operand regs 0.
REQ-023 Reset asserted mid-RUN or in DONE SHALL abort the comparison without any res_valid pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-024 Macro ECE385_CMP_SEQ_SIGNED_EN defined SHALL make the comparison two's-complement by inverting bit WIDTH-1 of both latched operands before the final nibble compare.
REQ-025 Without ECE385_CMP_SEQ_SIGNED_EN the comparison SHALL be unsigned; timing and handshake identical in both builds.

Structure
REQ-026 A shared package ece385_cmp_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the reset cascade constant (lt=0, eq=1, gt=0).
REQ-027 The comparator SHALL be the existing 4-bit cascadable comparator instantiated once as the sole sub-module; no duplicated compare logic in the controller.

Verification
REQ-028 NIBBLES=4, A=0x1234, B=0x1234, start, res_ready=1 -> res_valid 4 cycles later, eq=1, gt=0, lt=0, IDLE next cycle.
REQ-029 A=0x8001, B=0x7FFF unsigned -> gt=1; same with ECE385_CMP_SEQ_SIGNED_EN -> lt=1.
REQ-030 A=0x0F00, B=0x0E0F (upper nibble dominates lower) -> gt=1; A=0x0001, B=0x0002 -> lt=1.
REQ-031 res_ready held 0 for 10 cycles in DONE with A_in/B_in toggling and start pulsed -> outputs stable, no restart; release -> IDLE.
REQ-032 Reset_n pulsed low at RUN index 2 -> busy=0 immediately, no res_valid; next start A=B=0 -> eq=1 after 4 cycles.
REQ-033 Random 1000 operand pairs for NIBBLES=1 and 4, both builds -> results match scoreboard, one-hot outputs.
